decoder_3to8: RTL and testbench



---
 rtl/decoder_3to8_pkg.sv | 31 +++
 rtl/decoder_3to8_core.sv | 24 ++
 rtl/decoder_3to8.sv | 48 ++++
 tb/tb_decoder_3to8.sv | 130 +++++++++++++
 4 files changed

// File: rtl/decoder_3to8_pkg.sv
// Shared constants and small helpers for the registered 3-to-8 line decoder.
package decoder_3to8_pkg;

    localparam int DEC_WIDTH = 8;
    localparam int SEL_WIDTH = $clog2(DEC_WIDTH);

    typedef logic [DEC_WIDTH-1:0] dec_vec_t;
    typedef logic [SEL_WIDTH-1:0] dec_sel_t;

    // Map a positive-logic decode onto the configured output polarity.
    function automatic dec_vec_t apply_polarity(input dec_vec_t pos_val, input bit active_low);
        dec_vec_t result;
        if (active_low) begin
            result = ~pos_val;
        end else begin
            result = pos_val;
        end
        return result;
    endfunction

    // Value seen on the output with every line deasserted.
    function automatic dec_vec_t idle_value(input bit active_low);
        return apply_polarity({DEC_WIDTH{1'b0}}, active_low);
    endfunction

    // True when the vector is zero or has exactly one bit set.
    function automatic bit is_zero_or_onehot(input dec_vec_t v);
        return (v & (v - dec_vec_t'(1))) == {DEC_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Purely combinational positive-logic decode: enabled select becomes a one-hot vector.
module decoder3to8_core
    import decoder_3to8_pkg::*;
(
    input  logic [SEL_WIDTH-1:0] A,
    input  logic                 E,
    output logic [DEC_WIDTH-1:0] Y
);

    logic [DEC_WIDTH-1:0] onehot_s;

    // One-hot decode of the select, gated by the enable.
    always_comb begin
        onehot_s = {DEC_WIDTH{1'b0}};
        if (E) begin
            onehot_s = {{(DEC_WIDTH-1){1'b0}}, 1'b1} << A;
        end else begin
            onehot_s = {DEC_WIDTH{1'b0}};
        end
    end

    assign Y = onehot_s;

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 line decoder with enable, selectable output polarity and optional output register.
module decoder_3to8
    import decoder_3to8_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit OUT_REG    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_WIDTH-1:0] A,
    input  logic                 E,
    output logic [DEC_WIDTH-1:0] Y
);

    logic [DEC_WIDTH-1:0] pos_s;
    logic [DEC_WIDTH-1:0] pol_s;

    decoder3to8_core u_core (
        .A (A),
        .E (E),
        .Y (pos_s)
    );

    assign pol_s = apply_polarity(pos_s, ACTIVE_LOW);

    generate
        if (OUT_REG) begin : g_reg
            logic [DEC_WIDTH-1:0] y_r;

            // Output register; reset parks every line at its deasserted level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_r <= idle_value(ACTIVE_LOW);
                end else begin
                    y_r <= pol_s;
                end
            end

            assign Y = y_r;
        end else begin : g_comb
            // Clock and reset have no role in the combinational build.
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign Y        = pol_s;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: registered, active-low and combinational builds side by side.
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic [2:0] a;
    logic       e;
    logic [7:0] y_reg;
    logic [7:0] y_low;
    logic [7:0] y_comb;

    int checks   = 0;
    int failures = 0;

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3to8 #(.ACTIVE_LOW(1'b0), .OUT_REG(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .A(a), .E(e), .Y(y_reg));

    decoder_3to8 #(.ACTIVE_LOW(1'b1), .OUT_REG(1'b1)) dut_low (
        .clk(clk), .rst(rst), .A(a), .E(e), .Y(y_low));

    decoder_3to8 #(.ACTIVE_LOW(1'b0), .OUT_REG(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .A(a), .E(e), .Y(y_comb));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a live select: registered outputs idle before any edge.
        rst = 1'b1;
        e   = 1'b1;
        a   = 3'd5;
        #2;
        check_eq("rst_pre_edge_reg", y_reg, 8'h00);
        check_eq("rst_pre_edge_low", y_low, 8'hFF);
        check_eq("rst_comb_ignores", y_comb, 8'h20);
        tick();
        check_eq("rst_held_reg", y_reg, 8'h00);
        check_eq("rst_held_low", y_low, 8'hFF);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_release_no_edge", y_reg, 8'h00);
        tick();
        check_eq("rst_release_capture", y_reg, 8'h20);
        check_eq("rst_release_low", y_low, 8'hDF);

        // Sweep: registered output lags by one edge, combinational follows at once.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] prev;
            prev = (i == 0) ? 8'h20 : onehot_tbl[i-1];
            a = 3'(i);
            #1;
            check_eq($sformatf("sweep_hold_a%0d", i), y_reg, prev);
            check_eq($sformatf("sweep_comb_a%0d", i), y_comb, onehot_tbl[i]);
            tick();
            check_eq($sformatf("sweep_edge1_a%0d", i), y_reg, onehot_tbl[i]);
            tick();
            check_eq($sformatf("sweep_edge2_a%0d", i), y_reg, onehot_tbl[i]);
            check_eq($sformatf("sweep_low_a%0d", i), y_low, ~onehot_tbl[i]);
        end

        // Disable: all lines deasserted, select changes ignored.
        e = 1'b0;
        a = 3'd3;
        tick();
        check_eq("dis_reg", y_reg, 8'h00);
        check_eq("dis_low", y_low, 8'hFF);
        check_eq("dis_comb", y_comb, 8'h00);
        a = 3'd6;
        tick();
        check_eq("dis_toggle_a6", y_reg, 8'h00);
        a = 3'd1;
        tick();
        check_eq("dis_toggle_a1", y_reg, 8'h00);
        check_eq("dis_toggle_low", y_low, 8'hFF);

        // Enable and select change on the same edge.
        e = 1'b1;
        a = 3'd2;
        tick();
        check_eq("same_edge_reg", y_reg, 8'h04);
        check_eq("same_edge_low", y_low, 8'hFB);

        // Active-low spot values.
        a = 3'd0;
        tick();
        check_eq("low_a0", y_low, 8'hFE);
        a = 3'd3;
        tick();
        check_eq("low_a3", y_low, 8'hF7);
        check_eq("reg_a3", y_reg, 8'h08);

        // Mid-stream reset pulse between edges.
        a = 3'd6;
        tick();
        check_eq("mid_before", y_reg, 8'h40);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_async_reg", y_reg, 8'h00);
        check_eq("mid_async_low", y_low, 8'hFF);
        check_eq("mid_comb", y_comb, 8'h40);
        rst = 1'b0;
        #1;
        check_eq("mid_released_no_edge", y_reg, 8'h00);
        tick();
        check_eq("mid_recover_reg", y_reg, 8'h40);
        check_eq("mid_recover_low", y_low, 8'hBF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
